mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_if.sv | 37 +++
 rtl/mem_arbiter.sv | 110 +++++++++++
 tb/tb_mem_arbiter.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Bundle of the two requester ports and the memory-controller port of mem_arbiter.
// The slave modport is the arbiter's view; master is the requester/memory side.
interface mem_arbiter_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
);
  // Requester side
  logic              req0;
  logic              req1;
  logic              we0;
  logic              we1;
  logic [ADDR_W-1:0] addr0;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata0;
  logic [DATA_W-1:0] wdata1;
  logic              ack0;
  logic              ack1;
  logic [DATA_W-1:0] rdata;
  logic              busy;

  // Memory-controller side
  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_val;
  logic [DATA_W-1:0] mem_value;

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_value,
    output ack0, ack1, rdata, busy, mem_read, mem_write, mem_address, mem_val
  );

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_value,
    input  ack0, ack1, rdata, busy, mem_read, mem_write, mem_address, mem_val
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester round-robin arbiter in front of a single-ported memory controller.
// One transaction at a time: IDLE -> ISSUE (strobe) -> WAIT (MEM_LAT cycles) -> RESP (ack).
module mem_arbiter #(
  parameter int ADDR_W  = 10,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 1    // 1..15
) (
  input logic            clk,
  input logic            rst,
  mem_arbiter_if.slave   bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_t;

  // WAIT counts down from MEM_LAT-1 to 0, giving exactly MEM_LAT cycles.
  localparam logic [3:0] LP_WAIT_INIT = 4'(MEM_LAT - 1);

  state_t            r_state;
  state_t            w_next;
  logic              r_grant;       // requester owning the current transaction
  logic              r_last_grant;  // owner of the last completed transaction
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_rdata;
  logic [3:0]        r_cnt;

  logic              w_any_req;
  logic              w_pick;

  assign w_any_req = bus.req0 | bus.req1;
  // A lone request wins outright; on a tie the requester that did not go last wins.
  assign w_pick    = (bus.req0 & bus.req1) ? ~r_last_grant : bus.req1;

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // sees the values from before the edge, independent of statement order.
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic.
  always_comb begin
    // NOTE: default first, so no path through the case leaves w_next
    // unassigned and no latch is inferred.
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_any_req) w_next = S_ISSUE;
      S_ISSUE: w_next = S_WAIT;
      S_WAIT:  if (r_cnt == 4'd0) w_next = S_RESP;
      S_RESP:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Request latching, wait counter, read capture and round-robin history.
  always_ff @(posedge clk) begin
    // NOTE: the datapath registers are reset too, because the bus outputs
    // (rdata, mem_address, mem_val) must read zero straight out of reset.
    if (rst) begin
      r_grant      <= 1'b0;
      r_last_grant <= 1'b1;
      r_we         <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_rdata      <= '0;
      r_cnt        <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any_req) begin
            r_grant <= w_pick;
            r_we    <= w_pick ? bus.we1    : bus.we0;
            r_addr  <= w_pick ? bus.addr1  : bus.addr0;
            r_wdata <= w_pick ? bus.wdata1 : bus.wdata0;
          end
        end
        S_ISSUE: r_cnt <= LP_WAIT_INIT;
        S_WAIT: begin
          if (r_cnt == 4'd0) begin
            if (!r_we) r_rdata <= bus.mem_value;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_RESP:  r_last_grant <= r_grant;
        default: ;
      endcase
    end
  end

  // Outputs decoded from state and latched request fields.
  always_comb begin
    bus.busy        = (r_state != S_IDLE);
    bus.mem_read    = (r_state == S_ISSUE) && !r_we;
    bus.mem_write   = (r_state == S_ISSUE) &&  r_we;
    bus.ack0        = (r_state == S_RESP)  && !r_grant;
    bus.ack1        = (r_state == S_RESP)  &&  r_grant;
    bus.mem_address = r_addr;
    bus.mem_val     = r_wdata;
    bus.rdata       = r_rdata;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: one instance at MEM_LAT=1, one at MEM_LAT=3.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
module tb_mem_arbiter;

  localparam logic [31:0] BAD = 32'h0BAD_0BAD;

  logic clk = 1'b0;
  logic rst;

  int n_checks = 0;
  int n_fail   = 0;

  mem_arbiter_if #(.ADDR_W(10), .DATA_W(32)) a ();
  mem_arbiter_if #(.ADDR_W(10), .DATA_W(32)) b ();

  mem_arbiter #(.ADDR_W(10), .DATA_W(32), .MEM_LAT(1)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (a)
  );

  mem_arbiter #(.ADDR_W(10), .DATA_W(32), .MEM_LAT(3)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (b)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    a.req0 = 1'b1; a.req1 = 1'b0; a.we0 = 1'b0; a.we1 = 1'b0;
    a.addr0 = '0; a.addr1 = '0; a.wdata0 = '0; a.wdata1 = '0; a.mem_value = BAD;
    b.req0 = 1'b0; b.req1 = 1'b1; b.we0 = 1'b0; b.we1 = 1'b0;
    b.addr0 = '0; b.addr1 = '0; b.wdata0 = '0; b.wdata1 = '0; b.mem_value = BAD;

    // Reset with requests held high: they must be ignored.
    step(); step();
    check("rst_busy",    a.busy,        0);
    check("rst_ack0",    a.ack0,        0);
    check("rst_ack1",    a.ack1,        0);
    check("rst_mem_rd",  a.mem_read,    0);
    check("rst_mem_wr",  a.mem_write,   0);
    check("rst_rdata",   a.rdata,       0);
    check("rst_mem_adr", a.mem_address, 0);
    check("rst_mem_val", a.mem_val,     0);
    check("rst_b_busy",  b.busy,        0);
    rst = 1'b0; a.req0 = 1'b0; b.req1 = 1'b0;
    step();
    check("idle_busy", a.busy, 0);

    // Write addr 0 data 42 from requester 0 (cycle T).
    a.req0 = 1'b1; a.we0 = 1'b1; a.addr0 = 10'd0; a.wdata0 = 32'd42;
    step(); // T+1
    check("wr_strobe",   a.mem_write,   1);
    check("wr_no_read",  a.mem_read,    0);
    check("wr_addr",     a.mem_address, 0);
    check("wr_val",      a.mem_val,     42);
    check("wr_busy",     a.busy,        1);
    a.addr0 = 10'd7; a.wdata0 = 32'd9; // must be ignored
    step(); // T+2
    check("wr_strobe_off", a.mem_write,   0);
    check("wr_ack_early",  a.ack0,        0);
    check("wr_addr_hold",  a.mem_address, 0);
    check("wr_val_hold",   a.mem_val,     42);
    step(); // T+3
    check("wr_ack0",  a.ack0,  1);
    check("wr_ack1",  a.ack1,  0);
    check("wr_rdata", a.rdata, 0);
    a.req0 = 1'b0;
    step();
    check("wr_ack_off", a.ack0, 0);
    check("wr_idle",    a.busy, 0);

    // Read addr 0, memory returns 42 only in the final WAIT cycle.
    a.req0 = 1'b1; a.we0 = 1'b0; a.addr0 = 10'd0;
    step(); // T+1
    check("rd_strobe",   a.mem_read,    1);
    check("rd_no_write", a.mem_write,   0);
    check("rd_addr",     a.mem_address, 0);
    step(); // T+2
    a.mem_value = 32'd42;
    check("rd_ack_early", a.ack0, 0);
    step(); // T+3
    a.mem_value = BAD;
    check("rd_ack0",  a.ack0,  1);
    check("rd_rdata", a.rdata, 42);
    a.req0 = 1'b0;
    step();
    check("rd_ack_off", a.ack0, 0);

    // Tie after two grants to 0: requester 1 wins; reset it during WAIT.
    a.req0 = 1'b1; a.we0 = 1'b1; a.addr0 = 10'h10; a.wdata0 = 32'd100;
    a.req1 = 1'b1; a.we1 = 1'b1; a.addr1 = 10'h20; a.wdata1 = 32'd200;
    step(); // ISSUE
    check("pre_rst_grant1", a.mem_address, 32'h20);
    step(); // WAIT
    rst = 1'b1;
    step(); // IDLE after reset
    check("abort_busy",  a.busy,  0);
    check("abort_ack0",  a.ack0,  0);
    check("abort_ack1",  a.ack1,  0);
    check("abort_rdata", a.rdata, 0);
    rst = 1'b0;

    // Both held: grants alternate 0,1,0,1, one ack each.
    for (int i = 0; i < 4; i++) begin
      logic g;
      g = i[0];
      step(); // ISSUE
      check($sformatf("tie%0d_wr",   i), a.mem_write,   1);
      check($sformatf("tie%0d_addr", i), a.mem_address, g ? 32'h20 : 32'h10);
      check($sformatf("tie%0d_val",  i), a.mem_val,     g ? 32'd200 : 32'd100);
      step(); // WAIT
      check($sformatf("tie%0d_wait_ack", i), {a.ack1, a.ack0}, 2'b00);
      step(); // RESP
      check($sformatf("tie%0d_ack", i), {a.ack1, a.ack0}, g ? 2'b10 : 2'b01);
      step(); // IDLE
      check($sformatf("tie%0d_idle_ack",  i), {a.ack1, a.ack0}, 2'b00);
      check($sformatf("tie%0d_idle_busy", i), a.busy, 0);
      check($sformatf("tie%0d_rdata",     i), a.rdata, 0);
    end
    a.req0 = 1'b0; a.req1 = 1'b0;
    step();
    check("tie_done_busy", a.busy, 0);

    // Requester 1 alone right after a grant to 1; it drops req mid-transaction.
    a.req1 = 1'b1; a.we1 = 1'b0; a.addr1 = 10'd3;
    step(); // ISSUE
    check("r1_strobe", a.mem_read,    1);
    check("r1_addr",   a.mem_address, 3);
    a.req1 = 1'b0;
    step(); // WAIT
    a.mem_value = 32'h1234_5678;
    check("r1_ack_early", a.ack1, 0);
    step(); // RESP
    a.mem_value = BAD;
    check("r1_ack",   {a.ack1, a.ack0}, 2'b10);
    check("r1_rdata", a.rdata, 32'h1234_5678);
    step();
    check("r1_ack_off", a.ack1, 0);
    check("r1_idle",    a.busy, 0);

    // MEM_LAT=3 instance: read addr 5, address changed during WAIT.
    b.req0 = 1'b1; b.we0 = 1'b0; b.addr0 = 10'd5;
    step(); // T+1
    check("l3_strobe", b.mem_read,    1);
    check("l3_addr",   b.mem_address, 5);
    step(); // T+2
    b.addr0 = 10'd9;
    check("l3_ack_t2", b.ack0, 0);
    step(); // T+3
    check("l3_ack_t3",     b.ack0,        0);
    check("l3_addr_hold",  b.mem_address, 5);
    step(); // T+4, final WAIT
    b.mem_value = 32'hDEAD_BEEF;
    check("l3_ack_t4", b.ack0, 0);
    step(); // T+5
    b.mem_value = BAD;
    check("l3_ack",   b.ack0,  1);
    check("l3_rdata", b.rdata, 32'hDEAD_BEEF);
    b.req0 = 1'b0;
    step();
    check("l3_ack_off", b.ack0, 0);
    check("l3_idle",    b.busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
